// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters.
// Latency: 2 cycles from acceptance to o_rsp_valid (S1 issue register, S2 response register); 1 op/cycle sustained.
// Backpressure: i_rsp_ready low holds S2, S1 then fills and both ready outputs drop. Option macro: ALU_ARBITER_OPCHECK_EN.

// Combinational ALU. Codes outside the table return 0; shifts use b[4:0].
module alu (
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  output logic [31:0] o_alu_data
);
  logic [4:0] w_shamt;
  assign w_shamt = i_operand_b[4:0];

  // Decode the op code into the result.
  always_comb begin
    o_alu_data = 32'h0;
    case (i_alu_op)
      4'b0000: o_alu_data = i_operand_a + i_operand_b;
      4'b1000: o_alu_data = i_operand_a - i_operand_b;
      4'b0001: o_alu_data = i_operand_a << w_shamt;
      4'b0010: o_alu_data = {31'h0, ($signed(i_operand_a) < $signed(i_operand_b))};
      4'b0011: o_alu_data = {31'h0, (i_operand_a < i_operand_b)};
      4'b0100: o_alu_data = i_operand_a ^ i_operand_b;
      4'b0101: o_alu_data = i_operand_a >> w_shamt;
      4'b1101: o_alu_data = $unsigned($signed(i_operand_a) >>> w_shamt);
      4'b0110: o_alu_data = i_operand_a | i_operand_b;
      4'b0111: o_alu_data = i_operand_a & i_operand_b;
      4'b1111: o_alu_data = i_operand_b;
      default: o_alu_data = 32'h0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter logic RR_INIT    = 1'b0,
  parameter int   DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [3:0]            i_req0_op,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [3:0]            i_req1_op,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_id,
  output logic                  o_rsp_err,
  output logic                  o_busy
);
  localparam int ALU_WIDTH = 32;

  // The shared ALU is fixed at 32 bits; any other width must not build.
  if (DATA_WIDTH != ALU_WIDTH) begin : g_width_check
    $error("alu_arbiter: DATA_WIDTH must equal the ALU width (32)");
  end

  // S1 issue register
  logic                  r_s1_vld;
  logic [3:0]            r_s1_op;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic                  r_s1_id;
  // S2 response register
  logic                  r_s2_vld;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic                  r_s2_id;
  logic                  r_s2_err;
  // Requester that wins when both are valid
  logic                  r_ptr;

  logic                  w_s2_load;
  logic                  w_s1_accept;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_alu_data;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic                  w_rsp_err;

  // S1 drains into S2 whenever S2 is empty or being consumed this cycle.
  assign w_s2_load   = r_s1_vld & (~r_s2_vld | i_rsp_ready);
  assign w_s1_accept = ~r_s1_vld | w_s2_load;

  // A lone valid requester always wins; on contention the pointer decides.
  assign w_grant1 = i_req1_valid & (~i_req0_valid | r_ptr);
  assign w_grant0 = i_req0_valid & ~w_grant1;

  // Readies are masked during reset so every output reads 0 while it is held.
  assign o_req0_ready = w_grant0 & w_s1_accept & ~i_reset;
  assign o_req1_ready = w_grant1 & w_s1_accept & ~i_reset;
  assign w_xfer0      = o_req0_ready;
  assign w_xfer1      = o_req1_ready;
  assign w_xfer       = w_xfer0 | w_xfer1;

  alu u_alu (
    .i_alu_op    (r_s1_op),
    .i_operand_a (r_s1_a),
    .i_operand_b (r_s1_b),
    .o_alu_data  (w_alu_data)
  );

`ifdef ALU_ARBITER_OPCHECK_EN
  logic w_op_legal;

  // Flag op codes that are not in the ALU table.
  always_comb begin
    w_op_legal = 1'b0;
    case (r_s1_op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111: w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

  // An illegal op still produces a response slot, with zero data and err set.
  assign w_rsp_data = w_op_legal ? w_alu_data : '0;
  assign w_rsp_err  = ~w_op_legal;
`else
  assign w_rsp_data = w_alu_data;
  assign w_rsp_err  = 1'b0;
`endif

  // S1: capture the granted request; empty out when its result moves to S2.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_vld <= 1'b0;
      r_s1_op  <= 4'h0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_id  <= 1'b0;
    end else if (w_xfer) begin
      r_s1_vld <= 1'b1;
      r_s1_op  <= w_xfer1 ? i_req1_op : i_req0_op;
      r_s1_a   <= w_xfer1 ? i_req1_a  : i_req0_a;
      r_s1_b   <= w_xfer1 ? i_req1_b  : i_req0_b;
      r_s1_id  <= w_xfer1;
    end else if (w_s2_load) begin
      r_s1_vld <= 1'b0;
    end
  end

  // S2: load the ALU result from S1, clear once consumed, hold under backpressure.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_id   <= 1'b0;
      r_s2_err  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld  <= 1'b1;
      r_s2_data <= w_rsp_data;
      r_s2_id   <= r_s1_id;
      r_s2_err  <= w_rsp_err;
    end else if (i_rsp_ready & r_s2_vld) begin
      r_s2_vld  <= 1'b0;
    end
  end

  // Pointer hands priority to the requester that lost the last transfer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= RR_INIT;
    end else if (w_xfer) begin
      r_ptr <= w_xfer0;
    end
  end

  assign o_rsp_valid = r_s2_vld;
  assign o_rsp_data  = r_s2_data;
  assign o_rsp_id    = r_s2_id;
  assign o_rsp_err   = r_s2_err;
  assign o_busy      = r_s1_vld | r_s2_vld;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized and directed stimulus against a queue-level reference model.
module tb_alu_arbiter;
  logic        clk;
  logic        rst;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [3:0]  i_req0_op, i_req1_op;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_id, o_rsp_err, o_busy;

  alu_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] op; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic [31:0] data; logic id; logic err; logic dc; int stamp; } exp_t;

  req_t        src0[$], src1[$];
  exp_t        exq[$];
  logic [33:0] got[$];
  logic        ptr;
  int          cyc;
  int          n_pass, n_total;
`ifdef ALU_ARBITER_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic        e_r0, e_r1, e_v, e_dc;
  logic [37:0] e_vec;

  // Reference ALU straight from the op table.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ok);
    ok = 1'b1;
    r  = 32'h0;
    case (op)
      4'h0: r = a + b;
      4'h8: r = a - b;
      4'h1: r = a << b[4:0];
      4'h2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: r = (a < b) ? 32'd1 : 32'd0;
      4'h4: r = a ^ b;
      4'h5: r = a >> b[4:0];
      4'hD: r = $signed(a) >>> b[4:0];
      4'h6: r = a | b;
      4'h7: r = a & b;
      4'hF: r = b;
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void push_exp(input req_t q, input logic id);
    exp_t e;
    logic [31:0] r;
    logic ok;
    ref_alu(q.op, q.a, q.b, r, ok);
    e.id    = id;
    e.err   = OPCHECK && !ok;
    e.data  = (OPCHECK && !ok) ? 32'h0 : r;
    e.dc    = !OPCHECK && !ok;
    e.stamp = cyc;
    exq.push_back(e);
  endfunction

  // Present the head of each requester's pending list; idle ports get junk payloads.
  task automatic drive();
    i_req0_valid = (src0.size() > 0);
    i_req1_valid = (src1.size() > 0);
    if (src0.size() > 0) {i_req0_op, i_req0_a, i_req0_b} = src0[0];
    else {i_req0_op, i_req0_a, i_req0_b} = {4'($urandom), $urandom, $urandom};
    if (src1.size() > 0) {i_req1_op, i_req1_a, i_req1_b} = src1[0];
    else {i_req1_op, i_req1_a, i_req1_b} = {4'($urandom), $urandom, $urandom};
  endtask

  // Expected outputs: at most two operations in flight; the oldest is visible two edges after acceptance.
  function automatic void predict();
    logic g0, g1, acc, busy;
    g1   = i_req1_valid && (!i_req0_valid || ptr);
    g0   = i_req0_valid && !g1;
    acc  = (exq.size() < 2) || i_rsp_ready;
    e_r0 = g0 && acc;
    e_r1 = g1 && acc;
    e_v  = (exq.size() > 0) && (exq[0].stamp + 2 <= cyc);
    e_dc = e_v && exq[0].dc;
    busy = (exq.size() > 0);
    e_vec = {e_r0, e_r1, e_v, busy, 34'h0};
    if (e_v) e_vec[33:0] = {exq[0].id, exq[0].err, (e_dc ? 32'h0 : exq[0].data)};
  endfunction

  function automatic logic [37:0] act_masked();
    logic [37:0] v;
    v = {o_req0_ready, o_req1_ready, o_rsp_valid, o_busy, o_rsp_id, o_rsp_err, o_rsp_data};
    if (!e_v) v[33:0] = 34'h0;
    else if (e_dc) v[31:0] = 32'h0;
    return v;
  endfunction

  // Advance the model and the clock by one edge; outputs are sampled 1 time unit after the falling edge.
  task automatic tick();
    if (o_rsp_valid && i_rsp_ready) got.push_back({o_rsp_id, o_rsp_err, o_rsp_data});
    if (e_v && i_rsp_ready) void'(exq.pop_front());
    if (e_r0) begin push_exp(src0[0], 1'b0); void'(src0.pop_front()); ptr = 1'b1; end
    else if (e_r1) begin push_exp(src1[0], 1'b1); void'(src1.pop_front()); ptr = 1'b0; end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exq.delete(); src0.delete(); src1.delete(); got.delete();
    ptr = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] v;
    rst = 1'b1; i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_op = 4'h0; i_req1_op = 4'h0;
    i_req0_a = 32'h1; i_req0_b = 32'h2; i_req1_a = 32'h3; i_req1_b = 32'h4;
    @(negedge clk); @(negedge clk); #1;
    v = {o_req0_ready, o_req1_ready, o_rsp_valid, o_busy, o_rsp_id, o_rsp_err, o_rsp_data};
    n_total++;
    if (v !== 38'h0) $display("FAIL reset_outputs got %h want 0", v); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_contention();
    src0.push_back({4'h8, 32'h30, 32'h10});
    src1.push_back({4'hD, 32'h8000_0000, 32'h2});
    src0.push_back({4'h0, 32'h1, 32'h1});
    src1.push_back({4'h4, 32'hA, 32'h5});
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL contention cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (got.size() != 4 || got[0] !== {2'b00, 32'h20} || got[1] !== {2'b10, 32'hE000_0000}
        || got[2][33] !== 1'b0 || got[3][33] !== 1'b1)
      $display("FAIL contention_order got n=%0d first %h second %h", got.size(),
               (got.size() > 0) ? got[0] : 34'h0, (got.size() > 1) ? got[1] : 34'h0);
    else n_pass++;
    got.delete();
  endtask

  task automatic test_single();
    int seen;
    seen = 0;
    src0.push_back({4'h0, 32'h10, 32'h20});
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(); #1; predict();
      if (o_req0_ready) seen++;
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL single cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (seen != 1 || got.size() != 1 || got[0] !== {2'b00, 32'h30})
      $display("FAIL single_result ready_cycles=%0d n=%0d got %h want 1 ready cycle and 000000030", seen,
               got.size(), (got.size() > 0) ? got[0] : 34'h0);
    else n_pass++;
    got.delete();
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    src0.push_back({4'h4, 32'h0F, 32'hF0});
    src0.push_back({4'h6, 32'h0F, 32'hF0});
    src0.push_back({4'h7, 32'hFF, 32'hF0});
    for (int i = 0; i < 12; i++) begin
      i_rsp_ready = (i >= 5);
      drive(); #1; predict();
      if (i < 5 && o_req0_ready) acc++;
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL backpressure cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (acc != 2) $display("FAIL bp_accepted got %0d want 2", acc); else n_pass++;
    n_total++;
    if (got.size() != 3 || got[0] !== {2'b00, 32'hFF} || got[1] !== {2'b00, 32'hFF} || got[2] !== {2'b00, 32'hF0})
      $display("FAIL bp_order n=%0d want 3 results FF FF F0", got.size());
    else n_pass++;
    got.delete();
  endtask

  task automatic test_streaming();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) src1.push_back({4'hF, $urandom, 32'h1234_5678});
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL streaming cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    foreach (got[k]) if (got[k] !== {2'b10, 32'h1234_5678}) bad++;
    n_total++;
    if (got.size() != 20 || bad != 0) $display("FAIL stream_count got n=%0d bad=%0d want 20 bad=0", got.size(), bad);
    else n_pass++;
    got.delete();
  endtask

  task automatic test_illegal();
    src0.push_back({4'b1001, 32'h5, 32'h6});
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL illegal cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (got.size() != 1 || got[0][33:32] !== {1'b0, OPCHECK} || (OPCHECK && got[0][31:0] !== 32'h0))
      $display("FAIL illegal_rsp n=%0d got %h want id0 err=%0d", got.size(), (got.size() > 0) ? got[0] : 34'h0, OPCHECK);
    else n_pass++;
    got.delete();
  endtask

  task automatic test_random();
    int pushed, k;
    pushed = 0;
    for (int i = 0; i < 300; i++) begin
      if (src0.size() < 3 && $urandom_range(0, 1) == 1) begin src0.push_back({4'($urandom), $urandom, $urandom}); pushed++; end
      if (src1.size() < 3 && $urandom_range(0, 1) == 1) begin src1.push_back({4'($urandom), $urandom, $urandom}); pushed++; end
      i_rsp_ready = ($urandom_range(0, 9) < 7);
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL random cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    i_rsp_ready = 1'b1;
    k = 0;
    while ((src0.size() + src1.size() + exq.size()) > 0 && k < 50) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL random_drain cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
      k++;
    end
    n_total++;
    if (got.size() != pushed || exq.size() != 0)
      $display("FAIL random_count got %0d responses want %0d (pending %0d)", got.size(), pushed, exq.size());
    else n_pass++;
    got.delete();
  endtask

  task automatic test_reset_mid();
    logic [37:0] v;
    src0.push_back({4'h0, 32'h1, 32'h1});
    src0.push_back({4'h0, 32'h2, 32'h2});
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL fill cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (!(o_busy && o_rsp_valid)) $display("FAIL fill_state busy=%b rsp_valid=%b want 1 1", o_busy, o_rsp_valid);
    else n_pass++;
    i_req1_valid = 1'b1; i_rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    v = {o_req0_ready, o_req1_ready, o_rsp_valid, o_busy, o_rsp_id, o_rsp_err, o_rsp_data};
    n_total++;
    if (v !== 38'h0) $display("FAIL reset_async got %h want 0", v); else n_pass++;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    src0.push_back({4'h0, 32'h5, 32'h7});
    for (int i = 0; i < 5; i++) begin
      drive(); #1; predict();
      n_total++;
      if (act_masked() !== e_vec) $display("FAIL post_reset cyc=%0d got %h want %h", cyc, act_masked(), e_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (got.size() != 1 || got[0] !== {2'b00, 32'hC})
      $display("FAIL post_reset_rsp n=%0d got %h want 1 result 00000000C", got.size(), (got.size() > 0) ? got[0] : 34'h0);
    else n_pass++;
    got.delete();
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; ptr = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
